uart_rx_framed: RTL
===================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 receiver used by the host link.
//  Adds configurable data width, parity and stop bits, an input synchroniser,
//  3-sample majority voting, and a glitch-rejecting start check.
//  Reports parity, framing and overrun errors.
//  Delivers bytes to the command decoder over a valid/ready handshake, through a one-entry holding register.
// PARAMETERS
//  CLK_HZ     27000000  system clock frequency, Hz
//  BAUD       115200    line rate; DIV = CLK_HZ/BAUD (234 at defaults), HALF = DIV/2 (117)
//  DATA_BITS  8         payload bits per frame, 5..9
//  PARITY     0         0 none, 1 odd, 2 even
//  STOP_BITS  1         1 or 2
// PORTS
//  clock      in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-low reset
//  rx         in   1          asynchronous serial line, idle high
//  data       out  DATA_BITS  received payload, LSB = first bit on the line
//  valid      out  1          holding register full; data/errors stable while high
//  ready      in   1          consumer accepts when valid && ready at a clock edge
//  parity_err out  1          parity mismatch for the frame in data (qualified by valid)
//  frame_err  out  1          a stop bit sampled low for the frame in data (qualified by valid)
//  overrun    out  1          one-cycle pulse: a frame completed while the register was still full
// BEHAVIOUR
//  Reset (rst==0 at an edge):
//   - data=0, valid=0, parity_err=0, frame_err=0, overrun=0
//   - synchroniser flops = 1, state = IDLE
//   - Mid-frame reset abandons the frame; no partial delivery.
//  Input path: 2-flop synchroniser (rx_s), then majority of rx_s at bit-counter values HALF-1, HALF, HALF+1.
//  Bit counter: 0..DIV-1, cleared on every state entry.
//  FSM:
//   - IDLE: on rx_s==0 -> START.
//   - START: at HALF+1, vote==0 -> DATA; vote==1 -> IDLE (glitch, nothing reported).
//   - DATA: samples at each mid-bit, shifted in LSB-first.
//     After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
//   - PARITY: vote compared with XOR of the payload.
//     Odd parity: payload XOR parity == 1. Even parity: == 0.
//   - STOP: samples STOP_BITS stop bits; any low vote sets the frame_err candidate.
//     After the last stop sample: commit, then -> IDLE, or -> BREAK if the last stop bit was low.
//   - BREAK: wait for rx_s==1, then -> IDLE. Blocks a false start on a held-low line.
//  Mid-bit distance: full-bit distance from mid-bit to mid-bit = DIV clocks.
//  Commit:
//   - occurs the clock after the last stop vote; valid rises on that edge
//     (latency from mid-stop centre = 2 clocks).
//   - returning to IDLE at mid-stop allows back-to-back frames with no idle gap.
//  Handshake:
//   - valid stays high until an edge with ready==1, then drops next cycle unless a commit lands.
//   - commit with valid==0, or valid&&ready in the same cycle: load data and flags, valid=1, no overrun.
//   - commit with valid&&!ready: new frame discarded, old data/flags kept, overrun=1 for one cycle.
//  Error flags travel with their frame. A frame with frame_err is still delivered.
//  Widths: bit-counter width = $clog2(DIV); DATA_BITS-bit shift register; 2-bit stop counter.
//   No wrap: the counter clears before reaching DIV.
//  Elaboration error: DIV < 8, DATA_BITS outside 5..9, PARITY>2, or STOP_BITS not 1/2.
// STRUCTURE
//  Package uart_pkg:
//   - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
//   - FSM state localparams IDLE, START, DATA, PARITY, STOP, BREAK
//   - function uart_div(clk_hz, baud)
//  Sub-module uart_bit_timer:
//   - inputs: clear, enable
//   - outputs: mid_m1 / mid / mid_p1 strobes and a full-bit strobe, parametrised by DIV
//   - same timer reused by the planned uart_tx_framed.
//  Synchroniser, voter, FSM and holding register live in this module.
// TESTING
//  Defaults in all scenarios unless stated; a bench BFM drives rx at exactly DIV clocks per bit.
//  1. 8N1, send 0xA5 with ready=1 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0;
//     valid rises 2 clocks after the mid-stop centre.
//  2. PARITY=2: send 0x07 with parity bit 0 -> data=0x07, parity_err=1.
//     Then send 0x07 with parity bit 1 -> parity_err=0.
//  3. rx low for 50 clocks then high -> no valid, FSM back in IDLE.
//     Single-clock glitch inside a data bit -> correct byte (majority vote).
//  4. Stop bit driven low, line held low for 3 bit times -> data delivered with frame_err=1;
//     no second frame until rx returns high.
//  5. ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, overrun pulses once;
//     after ready=1, next frame 0x33 is delivered cleanly.
//  6. rst=0 asserted mid-DATA for one edge -> all outputs 0 next cycle;
//     the following full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the framed UART blocks.
//   - PAR_NONE / PAR_ODD / PAR_EVEN : parity mode selectors
//   - rx_state_t                    : receiver FSM states
//   - uart_div()                    : clocks per bit from clock and baud rate
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit-period counter shared by the framed UART receiver and transmitter.
//   Counts 0..DIV-1 while enabled and wraps, so a unit that stays in one
//   state sees strobes exactly DIV clocks apart.
// Ports
//   clock    in   system clock
//   rst      in   synchronous active-low reset
//   clear    in   force the count to 0 (used on every FSM state change)
//   enable   in   advance the count
//   mid_m1   out  count == HALF-1
//   mid      out  count == HALF
//   mid_p1   out  count == HALF+1
//   full_m2  out  count == DIV-3
//   full_m1  out  count == DIV-2
//   full     out  count == DIV-1 (full-bit strobe)
module uart_bit_timer #(
  parameter int DIV = 234
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic mid_m1,
  output logic mid,
  output logic mid_p1,
  output logic full_m2,
  output logic full_m1,
  output logic full
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  logic [CW-1:0] cnt;

  // The count returns to zero at DIV-1, so it never reaches DIV.
  always_ff @(posedge clock) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    end
  end

  assign mid_m1  = (cnt == CW'(HALF - 1));
  assign mid     = (cnt == CW'(HALF));
  assign mid_p1  = (cnt == CW'(HALF + 1));
  assign full_m2 = (cnt == CW'(DIV - 3));
  assign full_m1 = (cnt == CW'(DIV - 2));
  assign full    = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
//   glitch-rejecting start check, optional parity, 1 or 2 stop bits, and a
//   one-entry holding register with a valid/ready handshake.
// Ports
//   clock      in   system clock
//   rst        in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   data       out  received payload, LSB first on the line
//   valid      out  holding register full
//   ready      in   consumer accepts on valid && ready
//   parity_err out  parity mismatch for the frame in data
//   frame_err  out  a stop bit sampled low for the frame in data
//   overrun    out  one-cycle pulse: frame dropped because register was full
module uart_rx_framed import uart_pkg::*; #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);

  if (DIV < 8) begin : g_bad_div
    $error("uart_rx_framed: CLK_HZ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end

  rx_state_t            state, state_next;
  logic                 sync1, rx_s;
  logic                 v0, v1, vote;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bitcnt;
  logic [1:0]           stopcnt;
  logic                 pe_c, fe_c;
  logic                 shift_en, par_en, stop_en, commit;
  logic                 t_clear, t_en;
  logic                 mid_m1, mid, mid_p1, full_m2, full_m1, full;
  logic                 par_sum, par_bad;

  uart_bit_timer #(.DIV(DIV)) u_timer (
    .clock   (clock),
    .rst     (rst),
    .clear   (t_clear),
    .enable  (t_en),
    .mid_m1  (mid_m1),
    .mid     (mid),
    .mid_p1  (mid_p1),
    .full_m2 (full_m2),
    .full_m1 (full_m1),
    .full    (full)
  );

  // Synchroniser resets to the idle level so reset never looks like a start.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // The first two votes are captured in registers and the third is the live
  // rx_s on the decision strobe. START votes around HALF; the later states
  // were entered two clocks after the start centre, so their window sits at
  // DIV-3..DIV-1 to keep centres exactly DIV apart.
  always_ff @(posedge clock) begin
    if (!rst) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if ((state == START) ? mid_m1 : full_m2) v0 <= rx_s;
      if ((state == START) ? mid    : full_m1) v1 <= rx_s;
    end
  end

  assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  assign par_sum = (^shreg) ^ vote;
  assign par_bad = (PARITY == PAR_ODD) ? ~par_sum : par_sum;

  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and per-state strobes; the timer restarts on every state change.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (mid_p1) state_next = vote ? IDLE : DATA;
      DATA: begin
        if (full) begin
          shift_en = 1'b1;
          if (bitcnt == 4'(DATA_BITS - 1))
            state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (full) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (full) begin
          stop_en = 1'b1;
          if (stopcnt == 2'(STOP_BITS - 1)) begin
            commit     = 1'b1;
            state_next = vote ? IDLE : BREAK;
          end
        end
      end
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    t_clear = (state_next != state);
    t_en    = (state != IDLE) && (state != BREAK);
  end

  // Frame assembly; counters and error candidates are reset while in START.
  always_ff @(posedge clock) begin
    if (!rst) begin
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= '0;
      pe_c    <= 1'b0;
      fe_c    <= 1'b0;
    end else if (state == START) begin
      bitcnt  <= '0;
      stopcnt <= '0;
      pe_c    <= 1'b0;
      fe_c    <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg  <= {vote, shreg[DATA_BITS-1:1]};
        bitcnt <= bitcnt + 4'd1;
      end
      if (par_en) pe_c <= par_bad;
      if (stop_en) begin
        stopcnt <= stopcnt + 2'd1;
        if (!vote) fe_c <= 1'b1;
      end
    end
  end

  // Holding register: a commit into a full, unaccepted register is dropped
  // and flagged; an accept in the same cycle as a commit makes room for it.
  always_ff @(posedge clock) begin
    if (!rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= pe_c;
          frame_err  <= fe_c | ~vote;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
